// File: rtl/ifft_stream_ctrl.sv
// ifft_stream_ctrl
// Pulls one Hermitian-symmetric burst (SYMBOL_NUM symbols of FFT_POINT points)
// out of the Hermitian buffer and streams it to the IFFT core over AXI4-Stream.
// The buffer answers a read one cycle after read_ptr, so a small two-entry skid
// FIFO decouples that latency from IFFT back-pressure. Reads are only issued
// when the FIFO is guaranteed to have room for the returning word, which keeps
// at most two words outstanding between read_ptr and the output handshake.
// Each 8-bit I/Q sample is sign-extended to a 16-bit real/imag lane.
// When the final beat has been accepted, tx_done pulses once to re-arm the
// buffer, and the block waits for buff_full to fall before it can re-arm.

module ifft_stream_ctrl #(
    parameter int FFT_POINT  = 64,
    parameter int SYMBOL_NUM = 8,
    parameter int PTR_W      = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          buff_full,
    output logic [PTR_W-1:0]              read_ptr,
    input  logic [15:0]                   dout,
    output logic                          tx_done,
    output logic [31:0]                   m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          busy,
    output logic [$clog2(SYMBOL_NUM)-1:0] sym_idx
);

    localparam int TOTAL = FFT_POINT * SYMBOL_NUM;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int PT_W  = $clog2(FFT_POINT);
    localparam int SYM_W = $clog2(SYMBOL_NUM);

    localparam logic [CNT_W-1:0] TOTAL_C   = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(TOTAL - 1);
    localparam logic [PT_W-1:0]  PT_LAST   = PT_W'(FFT_POINT - 1);
    localparam logic [SYM_W-1:0] SYM_LAST  = SYM_W'(SYMBOL_NUM - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        DONE     = 2'd2,
        WAIT_CLR = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Read side: next address to issue, its position inside the symbol, and
    // whether a read issued last cycle is returning on dout this cycle.
    logic [CNT_W-1:0] rd_cnt;
    logic [PT_W-1:0]  rd_pt;
    logic             inflight;
    logic             inflight_last;

    // Skid FIFO storage and bookkeeping.
    logic [31:0]      fifo_data [2];
    logic             fifo_last [2];
    logic             wr_sel;
    logic             rd_sel;
    logic [1:0]       fifo_count;

    // Output side beat counter used to recognise the final beat.
    logic [CNT_W-1:0] out_cnt;

    logic             in_stream;
    logic             pop;
    logic             push;
    logic             issue;
    logic             last_pop;
    logic [2:0]       occupancy;
    logic [31:0]      push_word;

    assign in_stream     = (state == STREAM);
    assign m_axis_tvalid = (fifo_count != 2'd0);
    assign m_axis_tdata  = fifo_data[rd_sel];
    assign m_axis_tlast  = fifo_last[rd_sel];

    // Imag lane in the upper half, real lane in the lower half, both sign-extended.
    assign push_word = {{8{dout[7]}}, dout[7:0], {8{dout[15]}}, dout[15:8]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the state-derived busy and tx_done flags.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        tx_done   = 1'b0;
        case (state)
            IDLE: begin
                if (buff_full) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                busy = 1'b1;
                if (last_pop) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                tx_done   = 1'b1;
                state_nxt = WAIT_CLR;
            end
            WAIT_CLR: begin
                busy = 1'b1;
                if (!buff_full) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Handshake, push and read-issue decisions; a read is only issued when the
    // FIFO will still have room once that word returns next cycle.
    always_comb begin
        pop       = m_axis_tvalid & m_axis_tready;
        last_pop  = in_stream && pop && (out_cnt == LAST_BEAT);
        push      = in_stream && inflight;
        occupancy = {1'b0, fifo_count} + {2'b00, inflight};
        issue     = in_stream && (rd_cnt < TOTAL_C)
                    && (occupancy <= ({2'b00, pop} + 3'd1));
    end

    // Read address generation; read_ptr always presents the address being issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt        <= '0;
            rd_pt         <= '0;
            read_ptr      <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else if (!in_stream) begin
            rd_cnt        <= '0;
            rd_pt         <= '0;
            read_ptr      <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                rd_cnt        <= rd_cnt + 1'b1;
                read_ptr      <= PTR_W'(rd_cnt + 1'b1);
                inflight_last <= (rd_pt == PT_LAST);
                if (rd_pt == PT_LAST) begin
                    rd_pt <= '0;
                end else begin
                    rd_pt <= rd_pt + 1'b1;
                end
            end
        end
    end

    // Two-entry skid FIFO; the head stays put while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
            wr_sel     <= 1'b0;
            rd_sel     <= 1'b0;
            fifo_count <= 2'd0;
        end else if (!in_stream) begin
            wr_sel     <= 1'b0;
            rd_sel     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_sel] <= push_word;
                fifo_last[wr_sel] <= inflight_last;
                wr_sel            <= ~wr_sel;
            end
            if (pop) begin
                rd_sel <= ~rd_sel;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Output beat and symbol counters, advanced on accepted beats only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt <= '0;
            sym_idx <= '0;
        end else if (!in_stream) begin
            out_cnt <= '0;
            sym_idx <= '0;
        end else if (pop) begin
            out_cnt <= out_cnt + 1'b1;
            if (m_axis_tlast) begin
                if (sym_idx == SYM_LAST) begin
                    sym_idx <= '0;
                end else begin
                    sym_idx <= sym_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifft_stream_ctrl.sv
// Self-checking bench for ifft_stream_ctrl.
// A behavioural buffer model answers reads one cycle late; expected beats are
// computed straight from buffer contents as signed integers.
`timescale 1ns/1ps

module tb_ifft_stream_ctrl;

    localparam int TOTAL  = 512;
    localparam int POINTS = 64;

    logic        clk;
    logic        rst_n;
    logic        buff_full;
    logic [9:0]  read_ptr;
    logic [15:0] dout;
    logic        tx_done;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        busy;
    logic [2:0]  sym_idx;

    logic [15:0] mem      [TOTAL];
    logic [31:0] captured [TOTAL];

    int tests_run;
    int tests_failed;

    ifft_stream_ctrl #(
        .FFT_POINT (64),
        .SYMBOL_NUM(8),
        .PTR_W     (10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .buff_full    (buff_full),
        .read_ptr     (read_ptr),
        .dout         (dout),
        .tx_done      (tx_done),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .busy         (busy),
        .sym_idx      (sym_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hermitian buffer: registered read port with one cycle of latency.
    always @(posedge clk) begin
        dout <= mem[read_ptr[8:0]];
    end

    // Expected beat k: I and Q bytes taken as signed numbers, imag lane on top.
    function automatic logic [31:0] expect_beat(input int k);
        logic signed [7:0] i_byte;
        logic signed [7:0] q_byte;
        int re;
        int im;
        i_byte = mem[k][15:8];
        q_byte = mem[k][7:0];
        re = i_byte;
        im = q_byte;
        return {im[15:0], re[15:0]};
    endfunction

    task automatic load_pattern();
        for (int a = 0; a < TOTAL; a++) begin
            mem[a] = {a[7:0], ~a[7:0]};
        end
        mem[5] = 16'h807F;
        mem[6] = 16'h01FF;
    endtask

    task automatic load_random();
        for (int a = 0; a < TOTAL; a++) begin
            mem[a] = 16'($urandom);
        end
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        buff_full = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    // One burst: raises buff_full, drives tready, and checks every cycle.
    task automatic stream_burst(input string tag, input int duty, input int stall_beat,
                                input int stall_len, input int drop_cycle,
                                input int abort_beat, input bit check_timing);
        int          cyc;
        int          popped;
        int          popped_before;
        int          tlast_cnt;
        int          first_valid;
        int          stall_left;
        int          exp_sym;
        bit          stall_started;
        bit          in_stall;
        bit          prev_stalled;
        bit          finished;
        bit          aborted;
        bit          exp_last;
        logic [31:0] exp_data;
        logic [31:0] prev_data;

        cyc = 0; popped = 0; tlast_cnt = 0; first_valid = -1; stall_left = 0;
        stall_started = 0; in_stall = 0; prev_stalled = 0; finished = 0; aborted = 0;
        prev_data = '0;

        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        buff_full     = 1'b1;
        m_axis_tready = ($urandom_range(0, 99) < duty);

        while (!finished) begin
            @(negedge clk);
            popped_before = popped;
            if (cyc == 0) begin
                tests_run++;
                if (busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL %s start: busy=%b tvalid=%b, expected 0 0", tag, busy, m_axis_tvalid);
                end
            end
            if (cyc == 1) begin
                tests_run++;
                if (busy !== 1'b1 || read_ptr !== 10'd0) begin
                    tests_failed++;
                    $display("[TB] FAIL %s first_read: busy=%b read_ptr=%0d, expected 1 0", tag, busy, read_ptr);
                end
            end
            if (prev_stalled) begin
                tests_run++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data) begin
                    tests_failed++;
                    $display("[TB] FAIL %s hold cyc %0d: tvalid=%b tdata=%h, expected 1 %h", tag, cyc, m_axis_tvalid, m_axis_tdata, prev_data);
                end
            end
            if (in_stall) begin
                tests_run++;
                if (m_axis_tvalid !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL %s stall_valid cyc %0d: tvalid=%b, expected 1", tag, cyc, m_axis_tvalid);
                end
            end
            if (m_axis_tvalid === 1'b1) begin
                if (first_valid < 0) first_valid = cyc;
                tests_run++;
                if (popped >= TOTAL) begin
                    tests_failed++;
                    $display("[TB] FAIL %s extra_beat cyc %0d: tdata=%h, expected no beat", tag, cyc, m_axis_tdata);
                    finished = 1;
                    aborted  = 1;
                end else begin
                    exp_data = expect_beat(popped);
                    exp_last = ((popped % POINTS) == POINTS - 1);
                    exp_sym  = popped / POINTS;
                    if (m_axis_tdata !== exp_data || m_axis_tlast !== exp_last || sym_idx !== exp_sym[2:0]) begin
                        tests_failed++;
                        $display("[TB] FAIL %s beat %0d: tdata=%h tlast=%b sym=%0d, expected %h %b %0d",
                                 tag, popped, m_axis_tdata, m_axis_tlast, sym_idx, exp_data, exp_last, exp_sym);
                    end
                    if (m_axis_tready === 1'b1) begin
                        captured[popped] = m_axis_tdata;
                        if (m_axis_tlast === 1'b1) tlast_cnt++;
                        popped++;
                    end
                end
            end
            if (busy === 1'b1) begin
                tests_run++;
                if (int'(read_ptr) - popped_before > 2) begin
                    tests_failed++;
                    $display("[TB] FAIL %s read_ahead cyc %0d: read_ptr=%0d accepted=%0d, expected at most 2 ahead",
                             tag, cyc, read_ptr, popped_before);
                end
            end
            prev_stalled = (m_axis_tvalid === 1'b1) && (m_axis_tready !== 1'b1);
            prev_data    = m_axis_tdata;
            if (tx_done === 1'b1) begin
                tests_run++;
                if (popped != TOTAL || (check_timing && cyc != 515)) begin
                    tests_failed++;
                    $display("[TB] FAIL %s tx_done: cycle %0d after %0d beats, expected cycle 515 after %0d beats",
                             tag, cyc, popped, TOTAL);
                end
                finished = 1;
            end
            if (abort_beat >= 0 && popped >= abort_beat) begin
                finished = 1;
                aborted  = 1;
            end
            if (!finished && cyc >= 6000) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL %s timeout: %0d beats after %0d cycles, expected %0d beats", tag, popped, cyc, TOTAL);
                finished = 1;
                aborted  = 1;
            end
            if (!finished) begin
                @(posedge clk);
                #1;
                cyc++;
                if (cyc == drop_cycle) buff_full = 1'b0;
                if (stall_left > 0) begin
                    m_axis_tready = 1'b0;
                    stall_left--;
                    in_stall = 1;
                end else if (!stall_started && stall_beat >= 0 && popped == stall_beat) begin
                    stall_started = 1;
                    stall_left    = stall_len - 1;
                    m_axis_tready = 1'b0;
                    in_stall      = 1;
                end else begin
                    in_stall      = 0;
                    m_axis_tready = ($urandom_range(0, 99) < duty);
                end
            end
        end

        tests_run++;
        if (first_valid != 3) begin
            tests_failed++;
            $display("[TB] FAIL %s latency: first tvalid in cycle %0d, expected 3", tag, first_valid);
        end

        if (!aborted) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == drop_cycle) buff_full = 1'b0;
            @(negedge clk);
            tests_run++;
            if (tx_done !== 1'b0 || busy !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL %s pulse_width: tx_done=%b busy=%b, expected 0 1", tag, tx_done, busy);
            end
            tests_run++;
            if (popped != TOTAL || tlast_cnt != 8) begin
                tests_failed++;
                $display("[TB] FAIL %s totals: beats=%0d tlasts=%0d, expected %0d 8", tag, popped, tlast_cnt, TOTAL);
            end
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b1;
        buff_full     = 1'b0;
        m_axis_tready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (read_ptr !== 10'd0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 32'd0 ||
            tx_done !== 1'b0 || busy !== 1'b0 || sym_idx !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_values: ptr=%0d tvalid=%b tlast=%b tdata=%h tx_done=%b busy=%b sym=%0d, expected all 0",
                     read_ptr, m_axis_tvalid, m_axis_tlast, m_axis_tdata, tx_done, busy, sym_idx);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            tests_run++;
            if (busy !== 1'b0 || m_axis_tvalid !== 1'b0 || tx_done !== 1'b0 || read_ptr !== 10'd0) begin
                tests_failed++;
                $display("[TB] FAIL idle_after_reset: busy=%b tvalid=%b tx_done=%b ptr=%0d, expected 0 0 0 0",
                         busy, m_axis_tvalid, tx_done, read_ptr);
            end
        end
    endtask

    task automatic test_full_rate();
        load_pattern();
        stream_burst("full_rate", 100, -1, 0, -1, -1, 1'b1);
    endtask

    task automatic test_mapping();
        tests_run++;
        if (captured[5] !== 32'h007F_FF80) begin
            tests_failed++;
            $display("[TB] FAIL map_807f: tdata=%h, expected 007fff80", captured[5]);
        end
        tests_run++;
        if (captured[6] !== 32'hFFFF_0001) begin
            tests_failed++;
            $display("[TB] FAIL map_01ff: tdata=%h, expected ffff0001", captured[6]);
        end
    endtask

    task automatic test_wait_clr();
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            tests_run++;
            if (busy !== 1'b1 || m_axis_tvalid !== 1'b0 || tx_done !== 1'b0 || read_ptr !== 10'd0) begin
                tests_failed++;
                $display("[TB] FAIL wait_clr_hold: busy=%b tvalid=%b tx_done=%b ptr=%0d, expected 1 0 0 0",
                         busy, m_axis_tvalid, tx_done, read_ptr);
            end
        end
        @(posedge clk);
        #1 buff_full = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL wait_clr_release: busy=%b tvalid=%b, expected 0 0", busy, m_axis_tvalid);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_random_ready();
        load_random();
        stream_burst("random_ready", 30, -1, 0, 100, -1, 1'b0);
        go_idle();
    endtask

    task automatic test_stall();
        load_random();
        stream_burst("stall", 100, 200, 20, 100, -1, 1'b0);
        go_idle();
    endtask

    task automatic test_back_to_back();
        load_random();
        stream_burst("b2b_first", 100, -1, 0, 516, -1, 1'b1);
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_idle: busy=%b, expected 0", busy);
        end
        repeat (9) @(posedge clk);
        load_random();
        stream_burst("b2b_second", 100, -1, 0, 516, -1, 1'b1);
        go_idle();
    endtask

    task automatic test_reset_mid_burst();
        load_pattern();
        stream_burst("pre_reset", 100, -1, 0, -1, 300, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (read_ptr !== 10'd0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 32'd0 ||
            tx_done !== 1'b0 || busy !== 1'b0 || sym_idx !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_values: ptr=%0d tvalid=%b tlast=%b tdata=%h tx_done=%b busy=%b sym=%0d, expected all 0",
                     read_ptr, m_axis_tvalid, m_axis_tlast, m_axis_tdata, tx_done, busy, sym_idx);
        end
        repeat (3) begin
            @(negedge clk);
            tests_run++;
            if (tx_done !== 1'b0 || m_axis_tvalid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL mid_reset_hold: tx_done=%b tvalid=%b, expected 0 0", tx_done, m_axis_tvalid);
            end
        end
        stream_burst("replay", 100, -1, 0, -1, -1, 1'b1);
        go_idle();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_full_rate();
        test_mapping();
        test_wait_clr();
        test_random_ready();
        test_stall();
        test_back_to_back();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ifft_stream_ctrl.md
# ifft_stream_ctrl

Reads the Hermitian-symmetric burst (8 symbols × 64 points) out of the Hermitian buffer through its `read_ptr`/`dout` port. Streams it as AXI4-Stream frames into the IFFT core, sign-extending the 8-bit I/Q fields to 16 bits. It absorbs the buffer's 1-cycle read latency and IFFT back-pressure with a 2-entry skid FIFO. After the last beat it pulses `tx_done` to re-arm the buffer for the next burst.

## Interface
- `FFT_POINT`, 64, points per OFDM symbol; `tlast` period
- `SYMBOL_NUM`, 8, symbols per burst
- `PTR_W`, 10, width of `read_ptr`; FFT_POINT*SYMBOL_NUM ≤ 2^PTR_W

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `buff_full`  in  1  Hermitian buffer output-full status (level)
- `read_ptr`  out  PTR_W  buffer read address, registered
- `dout`  in  16  buffer read data, {I[7:0], Q[7:0]}, valid 1 cycle after `read_ptr`
- `tx_done`  out  1  1-cycle pulse; clears the buffer's counters/flags
- `m_axis_tdata`  out  32  {sext16(Q), sext16(I)}: imag in [31:16], real in [15:0]
- `m_axis_tvalid`  out  1  AXI-S valid
- `m_axis_tready`  in  1  AXI-S ready from IFFT
- `m_axis_tlast`  out  1  high on the last point of each symbol
- `busy`  out  1  high in STREAM, DONE and WAIT_CLR
- `sym_idx`  out  3  index of the symbol currently being output, 0..SYMBOL_NUM-1

## Operation
- FSM states and transitions:
  - IDLE → STREAM when `buff_full`=1.
  - STREAM → DONE after handshake of beat FFT_POINT*SYMBOL_NUM-1 (511).
  - DONE → WAIT_CLR unconditionally; `tx_done`=1 in DONE only.
  - WAIT_CLR → IDLE when `buff_full`=0.
- Read issue, STREAM only:
  - A read is issued in a cycle when `rd_cnt` < 512 and (fifo_count + inflight − pop) ≤ 1. pop = `tvalid`&`tready`; inflight = 1 if a read was issued the previous cycle.
  - On issue, `read_ptr` ← `rd_cnt`, and `rd_cnt` increments.
  - The cycle after an issue, `dout` is pushed into the FIFO.
- The FIFO is 2 entries and never overflows. `tvalid` = FIFO non-empty. `tdata`/`tlast` come from the FIFO head.
- Mapping: I = dout[15:8], Q = dout[7:0], two's complement. Real = {{8{I[7]}},I}; imag = {{8{Q[7]}},Q}.
- Counters:
  - `tlast` is set when the entry's address mod FFT_POINT = FFT_POINT−1.
  - `sym_idx` is the output beat counter divided by FFT_POINT. It increments on each `tlast` handshake and wraps to 0 in DONE.
- Reset values, applied asynchronously on `rst_n`=0:
  - State IDLE.
  - `read_ptr`=0, `tvalid`=0, `tlast`=0, `tdata`=0, `tx_done`=0, `busy`=0, `sym_idx`=0.
  - FIFO empty; `rd_cnt`, beat counter and inflight cleared.
- Reset mid-burst: all state is discarded and no `tx_done` is issued. If `buff_full` is still high after release, the burst replays from address 0.
- A `buff_full` drop during STREAM is ignored; the block completes the burst.
- `tdata`/`tlast` are held stable while `tvalid`=1 and `tready`=0.

## Timing
- Cycle 0: `buff_full`=1 is sampled in IDLE.
- Cycle 1: STREAM; `read_ptr`=0 is driven.
- Cycle 2: `dout` holds address 0 and is pushed.
- Cycle 3: `tvalid`=1 with beat 0.
- Latency from `buff_full` to first `tvalid` is 3 cycles.
- With `tready` held at 1: 512 consecutive beats in cycles 3..514. `tlast` falls in cycles 66, 130, …, 514. `tx_done` is high in cycle 515.
- After `tready` returns high from a stall, output resumes the next cycle with no lost or duplicated beat.
- `tx_done` lasts exactly 1 cycle. No new burst starts until `buff_full` has been observed low.

## Test plan
- Preload buffer with addr[7:0] pattern, `tready`=1 → 512 beats in order in cycles 3..514; `tlast` on beats 63 and 127 through 511 (8 total); one `tx_done` pulse in cycle 515.
- `dout`=16'h80_7F → `tdata`=32'h007F_FF80. `dout`=16'h01_FF → `tdata`=32'hFFFF_0001.
- Random `tready` at 30% duty → all 512 beats delivered exactly once and in order. `tdata` is stable under stall. `read_ptr` never runs more than 2 entries ahead of the output handshake.
- `tready`=0 for 20 cycles at beat 200 → `tvalid` stays 1 and `tdata` holds beat 200. At most 2 reads are outstanding, and the stream resumes at 200.
- `rst_n` pulsed low at beat 300 while `buff_full` stays high → all outputs are at reset values immediately and `tx_done` is not asserted. The burst restarts at address 0 three cycles after release.
- Model `buff_full` to drop 1 cycle after `tx_done`, then rise again 10 cycles later → the FSM passes WAIT_CLR → IDLE and a second burst starts. Holding `buff_full` high after `tx_done` keeps the FSM in WAIT_CLR.
